// File: rtl/mips_factorial_soc_if.sv
// GPIO bundle between the SoC and its environment.
//   gpI1/gpI2 : general-purpose inputs (driven by environment)
//   gpO1/gpO2 : general-purpose outputs (driven by the SoC)
// slave  : SoC side
// master : environment / testbench side
interface mips_factorial_soc_if;
  logic [31:0] gpI1;
  logic [31:0] gpI2;
  logic [31:0] gpO1;
  logic [31:0] gpO2;

  modport slave  (input  gpI1, gpI2, output gpO1, gpO2);
  modport master (output gpI1, gpI2, input  gpO1, gpO2);
endinterface

// File: rtl/mips_factorial_soc.sv
// Single-cycle MIPS32-subset SoC: CPU, 64-word instruction ROM holding the
// factorial program, 64-word data RAM and memory-mapped GPIO at 0x900.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   gpio (slave)      : gpI1 (operand n), gpI2, gpO1 (echo of n), gpO2 (n!)
//   pc_current, instr : PC and instruction word this cycle
//   alu_out           : ALU result this cycle (also the data address)
//   we_dm, wd_dm      : store strobe and store data this cycle
//   ra3 / rd3         : debug register-file read port (combinational)
module mips_factorial_soc (
  input  logic                       clk,
  input  logic                       rst,
  mips_factorial_soc_if.slave        gpio,
  output logic [31:0]                pc_current,
  output logic [31:0]                instr,
  output logic [31:0]                alu_out,
  output logic                       we_dm,
  output logic [31:0]                wd_dm,
  input  logic [4:0]                 ra3,
  output logic [31:0]                rd3
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03, OP_BEQ  = 6'h04,
    OP_BNE   = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
    OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_LUI   = 6'h0F, OP_LW   = 6'h23,
    OP_SW    = 6'h2B
  } op_e;

  typedef enum logic [5:0] {
    F_SLL  = 6'h00, F_SRL  = 6'h02, F_JR   = 6'h08, F_MFHI = 6'h10,
    F_MFLO = 6'h12, F_MULTU = 6'h19, F_ADD = 6'h20, F_ADDU = 6'h21,
    F_SUB  = 6'h22, F_SUBU = 6'h23, F_AND  = 6'h24, F_OR   = 6'h25,
    F_SLT  = 6'h2A
  } funct_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI
  } alu_op_e;

  typedef enum logic [2:0] {
    WB_ALU, WB_MEM, WB_PC4, WB_HI, WB_LO
  } wb_sel_e;

  // Architectural state
  logic [31:0] pc_q, pc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] gpo1_q, gpo1_d;
  logic [31:0] gpo2_q, gpo2_d;
  logic [31:0] regs_q [32];
  logic [31:0] ram_q  [64];

  // Instruction fields
  op_e         opcode;
  funct_e      funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] imm_sext, imm_zext;

  // Decode outputs
  alu_op_e     alu_op;
  wb_sel_e     wb_sel;
  logic        alu_src_imm, use_zext;
  logic        rf_we, mem_we, hilo_we;
  logic        br_eq, br_ne, jmp, jr;
  logic [4:0]  rf_wa;

  // Datapath
  logic [31:0] rs_val, rt_val, alu_b, alu_res, rf_wd, mem_rdata;
  logic [31:0] pc_plus4, br_target, j_target;
  logic [63:0] product;
  logic        ram_sel, gpio_sel;

  // Program: n = gpI1[3:0]; gpO1 = n; r = 1; while (n >= 2) r *= n--; gpO2 = r;
  // then jal to the 0x5C self-loop (leaves $31 = 0x34).
  always_comb begin
    instr = '0;
    case (pc_q[7:2])
      6'd0:  instr = 32'h2408_0900; // addiu $8, $0, 0x900
      6'd1:  instr = 32'h8D09_0000; // lw    $9, 0($8)
      6'd2:  instr = 32'h3129_000F; // andi  $9, $9, 0xF
      6'd3:  instr = 32'hAD09_0008; // sw    $9, 8($8)
      6'd4:  instr = 32'h240A_0001; // addiu $10, $0, 1
      6'd5:  instr = 32'h292C_0002; // slti  $12, $9, 2     (0x14 loop)
      6'd6:  instr = 32'h1580_0004; // bne   $12, $0, 0x2C
      6'd7:  instr = 32'h0149_0019; // multu $10, $9
      6'd8:  instr = 32'h0000_5012; // mflo  $10
      6'd9:  instr = 32'h2129_FFFF; // addi  $9, $9, -1
      6'd10: instr = 32'h0800_0005; // j     0x14
      6'd11: instr = 32'hAD0A_000C; // sw    $10, 12($8)    (0x2C)
      6'd12: instr = 32'h0C00_0017; // jal   0x5C
      6'd23: instr = 32'h0800_0017; // j     0x5C           (0x5C halt)
      default: instr = '0;
    endcase
  end

  assign opcode   = op_e'(instr[31:26]);
  assign funct    = funct_e'(instr[5:0]);
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign imm      = instr[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};

  assign rs_val = (rs == 5'd0) ? '0 : regs_q[rs];
  assign rt_val = (rt == 5'd0) ? '0 : regs_q[rt];
  assign rd3    = (ra3 == 5'd0) ? '0 : regs_q[ra3];

  always_comb begin
    alu_op      = ALU_ADD;
    wb_sel      = WB_ALU;
    alu_src_imm = 1'b0;
    use_zext    = 1'b0;
    rf_we       = 1'b0;
    rf_wa       = rd;
    mem_we      = 1'b0;
    hilo_we     = 1'b0;
    br_eq       = 1'b0;
    br_ne       = 1'b0;
    jmp         = 1'b0;
    jr          = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU: begin rf_we = 1'b1; alu_op = ALU_ADD; end
          F_SUB, F_SUBU: begin rf_we = 1'b1; alu_op = ALU_SUB; end
          F_AND:         begin rf_we = 1'b1; alu_op = ALU_AND; end
          F_OR:          begin rf_we = 1'b1; alu_op = ALU_OR;  end
          F_SLT:         begin rf_we = 1'b1; alu_op = ALU_SLT; end
          F_SLL:         begin rf_we = 1'b1; alu_op = ALU_SLL; end
          F_SRL:         begin rf_we = 1'b1; alu_op = ALU_SRL; end
          F_JR:          jr = 1'b1;
          F_MULTU:       hilo_we = 1'b1;
          F_MFHI:        begin rf_we = 1'b1; wb_sel = WB_HI; end
          F_MFLO:        begin rf_we = 1'b1; wb_sel = WB_LO; end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin rf_we = 1'b1; rf_wa = rt; alu_src_imm = 1'b1; end
      OP_SLTI: begin rf_we = 1'b1; rf_wa = rt; alu_src_imm = 1'b1; alu_op = ALU_SLT; end
      OP_ANDI: begin
        rf_we = 1'b1; rf_wa = rt; alu_src_imm = 1'b1; use_zext = 1'b1; alu_op = ALU_AND;
      end
      OP_ORI: begin
        rf_we = 1'b1; rf_wa = rt; alu_src_imm = 1'b1; use_zext = 1'b1; alu_op = ALU_OR;
      end
      OP_LUI:  begin rf_we = 1'b1; rf_wa = rt; alu_op = ALU_LUI; end
      OP_LW:   begin rf_we = 1'b1; rf_wa = rt; alu_src_imm = 1'b1; wb_sel = WB_MEM; end
      OP_SW:   begin mem_we = 1'b1; alu_src_imm = 1'b1; end
      OP_BEQ:  br_eq = 1'b1;
      OP_BNE:  br_ne = 1'b1;
      OP_J:    jmp = 1'b1;
      OP_JAL:  begin jmp = 1'b1; rf_we = 1'b1; rf_wa = 5'd31; wb_sel = WB_PC4; end
      default: ;
    endcase
  end

  assign alu_b = alu_src_imm ? (use_zext ? imm_zext : imm_sext) : rt_val;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD: alu_res = rs_val + alu_b;
      ALU_SUB: alu_res = rs_val - alu_b;
      ALU_AND: alu_res = rs_val & alu_b;
      ALU_OR:  alu_res = rs_val | alu_b;
      ALU_SLT: alu_res = {31'b0, $signed(rs_val) < $signed(alu_b)};
      ALU_SLL: alu_res = alu_b << shamt;
      ALU_SRL: alu_res = alu_b >> shamt;
      ALU_LUI: alu_res = {imm, 16'h0000};
      default: alu_res = '0;
    endcase
  end

  // Data-side address decode: RAM at 0x000-0x0FC, GPIO at 0x900-0x90C
  assign ram_sel  = (alu_res[31:8] == 24'h0);
  assign gpio_sel = (alu_res[31:4] == 28'h000_0090);

  always_comb begin
    mem_rdata = '0;
    if (ram_sel) begin
      mem_rdata = ram_q[alu_res[7:2]];
    end else if (gpio_sel) begin
      case (alu_res[3:2])
        2'd0: mem_rdata = gpio.gpI1;
        2'd1: mem_rdata = gpio.gpI2;
        2'd2: mem_rdata = gpo1_q;
        2'd3: mem_rdata = gpo2_q;
        default: mem_rdata = '0;
      endcase
    end
  end

  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign product   = {32'h0, rs_val} * {32'h0, rt_val};

  always_comb begin
    rf_wd = alu_res;
    case (wb_sel)
      WB_MEM:  rf_wd = mem_rdata;
      WB_PC4:  rf_wd = pc_plus4;
      WB_HI:   rf_wd = hi_q;
      WB_LO:   rf_wd = lo_q;
      default: rf_wd = alu_res;
    endcase
  end

  always_comb begin
    pc_d   = pc_plus4;
    hi_d   = hi_q;
    lo_d   = lo_q;
    gpo1_d = gpo1_q;
    gpo2_d = gpo2_q;
    if (jr) begin
      pc_d = rs_val;
    end else if (jmp) begin
      pc_d = j_target;
    end else if ((br_eq && (rs_val == rt_val)) || (br_ne && (rs_val != rt_val))) begin
      pc_d = br_target;
    end
    if (hilo_we) begin
      hi_d = product[63:32];
      lo_d = product[31:0];
    end
    if (mem_we && gpio_sel && (alu_res[3:2] == 2'd2)) gpo1_d = rt_val;
    if (mem_we && gpio_sel && (alu_res[3:2] == 2'd3)) gpo2_d = rt_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      gpo1_q <= '0;
      gpo2_q <= '0;
      regs_q <= '{default: '0};
    end else begin
      pc_q   <= pc_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      gpo1_q <= gpo1_d;
      gpo2_q <= gpo2_d;
      if (rf_we && (rf_wa != 5'd0)) regs_q[rf_wa] <= rf_wd;
    end
  end

  // Data RAM keeps its contents across reset; reset only suppresses the store.
  always_ff @(posedge clk) begin
    if (!rst && mem_we && ram_sel) ram_q[alu_res[7:2]] <= rt_val;
  end

  assign pc_current = pc_q;
  assign alu_out    = alu_res;
  assign we_dm      = mem_we;
  assign wd_dm      = rt_val;
  assign gpio.gpO1  = gpo1_q;
  assign gpio.gpO2  = gpo2_q;

endmodule

// File: tb/tb_mips_factorial_soc.sv
module tb_mips_factorial_soc;

  logic        clk;
  logic        rst;
  logic [31:0] pc_current, instr, alu_out, wd_dm, rd3;
  logic        we_dm;
  logic [4:0]  ra3;

  int unsigned total;
  int unsigned bad;
  int unsigned cycles;

  mips_factorial_soc_if gpio_if ();

  mips_factorial_soc dut (
    .clk        (clk),
    .rst        (rst),
    .gpio       (gpio_if.slave),
    .pc_current (pc_current),
    .instr      (instr),
    .alu_out    (alu_out),
    .we_dm      (we_dm),
    .wd_dm      (wd_dm),
    .ra3        (ra3),
    .rd3        (rd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One reset edge with gpI1 = n, then release; returns at a negedge.
  task automatic do_reset(input logic [31:0] n);
    @(negedge clk);
    rst = 1'b1;
    gpio_if.gpI1 = n;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_halt(input string tag);
    cycles = 0;
    while (pc_current != 32'h5C && cycles < 300) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
      ra3 = 5'd0;
      #1;
      check32({tag, "_rd3_zero"}, rd3, 32'h0);
    end
    check32({tag, "_halt_pc"}, pc_current, 32'h5C);
  endtask

  task automatic run_case(input string tag, input logic [31:0] n,
                          input logic [31:0] exp_o1, input logic [31:0] exp_o2);
    do_reset(n);
    run_to_halt(tag);
    check32({tag, "_gpO2"}, gpio_if.gpO2, exp_o2);
    check32({tag, "_gpO1"}, gpio_if.gpO1, exp_o1);
    check32({tag, "_instr"}, instr, 32'h0800_0017);
    ra3 = 5'd31;
    #1;
    check32({tag, "_ra"}, rd3, 32'h34);
    ra3 = 5'd10;
    #1;
    check32({tag, "_r10"}, rd3, exp_o2);
    ra3 = 5'd0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    ra3   = 5'd0;
    gpio_if.gpI1 = 32'h0;
    gpio_if.gpI2 = 32'hDEAD_BEEF;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check32("rst_pc", pc_current, 32'h0);
    check32("rst_gpO1", gpio_if.gpO1, 32'h0);
    check32("rst_gpO2", gpio_if.gpO2, 32'h0);
    check32("rst_instr", instr, 32'h2408_0900);
    check32("rst_alu", alu_out, 32'h900);
    check32("rst_we", {31'b0, we_dm}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      ra3 = 5'(i);
      #1;
      check32("rst_rd3", rd3, 32'h0);
    end
    ra3 = 5'd0;
    rst = 1'b0;

    // Store of n to gpO1 at 0x0C, three edges after release
    do_reset(32'd5);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check32("sw_pc", pc_current, 32'h0C);
    check32("sw_we", {31'b0, we_dm}, 32'h1);
    check32("sw_wd", wd_dm, 32'h5);
    check32("sw_addr", alu_out, 32'h908);
    run_to_halt("n5");
    check32("n5_gpO2", gpio_if.gpO2, 32'd120);

    run_case("n2", 32'd2, 32'd2, 32'd2);
    run_case("n3", 32'd3, 32'd3, 32'd6);
    run_case("n4", 32'd4, 32'd4, 32'd24);
    run_case("n0", 32'd0, 32'd0, 32'd1);
    run_case("n1", 32'd1, 32'd1, 32'd1);
    run_case("n_mask", 32'hFFFF_FF13, 32'd3, 32'd6);
    run_case("n15", 32'd15, 32'd15, 32'd2004310016);
    run_case("n12", 32'd12, 32'd12, 32'd479001600);

    // Parked: 20 more cycles, gpI1 change must not matter
    gpio_if.gpI1 = 32'd7;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      check32("park_pc", pc_current, 32'h5C);
    end
    check32("park_gpO2", gpio_if.gpO2, 32'd479001600);
    check32("park_gpO1", gpio_if.gpO1, 32'd12);

    // Reset mid-loop: 15 edges after release with n=4 sits at 0x24 (addi)
    do_reset(32'd4);
    repeat (15) begin
      @(posedge clk);
      @(negedge clk);
    end
    check32("mid_pc", pc_current, 32'h24);
    check32("mid_gpO1", gpio_if.gpO1, 32'd4);
    rst = 1'b1;
    gpio_if.gpI1 = 32'd3;
    @(posedge clk);
    @(negedge clk);
    check32("mid_rst_pc", pc_current, 32'h0);
    check32("mid_rst_gpO1", gpio_if.gpO1, 32'h0);
    ra3 = 5'd9;
    #1;
    check32("mid_rst_r9", rd3, 32'h0);
    ra3 = 5'd0;
    rst = 1'b0;
    run_to_halt("restart");
    check32("restart_gpO2", gpio_if.gpO2, 32'd6);
    check32("restart_gpO1", gpio_if.gpO1, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
